// File: rtl/hdbn_b_insert.sv
// hdbn_b_insert: HDBn B-pulse insertion stage.
// A delay line of ORDER+1 symbol stages (oldest stage drives the output).
// When a V marker enters stage 0 and the number of marks since the previous
// V is even, the zero leaving for the output stage is replaced by a B.
// Optional build macro HDBN_B_STATS_EN adds saturating b_count/v_count ports.
module hdbn_b_insert #(
  parameter int unsigned ORDER   = 3,
  parameter bit          FIRST_B = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] origin_data,
  output logic [1:0] encoding_data,
  output logic       encoding_data_instruction,
  output logic       sym_err
`ifdef HDBN_B_STATS_EN
  ,
  output logic [15:0] b_count,
  output logic [15:0] v_count
`endif
);

  localparam int unsigned DEPTH = ORDER + 1;
  localparam int unsigned CW    = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(ORDER);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_MARK = 2'b01;
  localparam logic [1:0] SYM_V    = 2'b10;
  localparam logic [1:0] SYM_B    = 2'b11;

  logic [1:0]          state;
  logic [CW-1:0]       drain_cnt;
  logic [ORDER:0][1:0] stage_sym;
  logic [ORDER:0]      stage_vld;
  logic                parity;
  logic                v_seen;

  logic                shift;
  logic [1:0]          in_sym;
  logic                in_v;
  logic                in_mark;
  logic                in_bad;
  logic                sub_b;
  logic [ORDER:0][1:0] sym_nxt;
  logic [ORDER:0]      vld_nxt;

  // Next contents of the delay line, including B substitution at the output stage
  always_comb begin
    shift   = en || (state != IDLE);
    in_bad  = en && (origin_data == SYM_B);
    in_v    = en && (origin_data == SYM_V);
    in_mark = en && (origin_data == SYM_MARK);
    in_sym  = (en && !in_bad) ? origin_data : SYM_ZERO;
    sub_b   = in_v && (v_seen || FIRST_B) && !parity &&
              stage_vld[ORDER-1] && (stage_sym[ORDER-1] == SYM_ZERO);
    sym_nxt = {stage_sym[ORDER-1:0], in_sym};
    vld_nxt = {stage_vld[ORDER-1:0], en};
    if (sub_b) begin
      sym_nxt[ORDER] = SYM_B;
    end
  end

  // Delay line and symbol-error pulse
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stage_sym <= '0;
      stage_vld <= '0;
      sym_err   <= 1'b0;
    end else begin
      sym_err <= in_bad;
      if (shift) begin
        stage_sym <= sym_nxt;
        stage_vld <= vld_nxt;
      end
    end
  end

  // Burst control FSM with parity and V-seen tracking
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      parity    <= 1'b0;
      v_seen    <= 1'b0;
    end else begin
      // A B is only ever inserted alongside a V, and the V clears parity,
      // so the toggle a B would cause is subsumed by that clear.
      if (in_v) begin
        parity <= 1'b0;
        v_seen <= 1'b1;
      end else if (in_mark) begin
        parity <= ~parity;
      end
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state     <= DRAIN;
            drain_cnt <= CW'(1);
          end
        end
        DRAIN: begin
          if (en) begin
            state <= RUN;
          end else if (drain_cnt == LAST) begin
            state     <= IDLE;
            drain_cnt <= '0;
            parity    <= 1'b0;
            v_seen    <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign encoding_data_instruction = stage_vld[ORDER];
  assign encoding_data             = stage_vld[ORDER] ? stage_sym[ORDER] : SYM_ZERO;

`ifdef HDBN_B_STATS_EN
  // Saturating counters of inserted B pulses and V symbols reaching the output
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      b_count <= '0;
      v_count <= '0;
    end else begin
      if (sub_b && (b_count != '1)) begin
        b_count <= b_count + 1'b1;
      end
      if (shift && vld_nxt[ORDER] && (sym_nxt[ORDER] == SYM_V) && (v_count != '1)) begin
        v_count <= v_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hdbn_b_insert.sv
// Bench for hdbn_b_insert: table of {en, input, expected output symbol}
// feeding a scoreboard, plus hand sequences for reset and an ORDER=2 instance.
module tb_hdbn_b_insert;

  localparam int unsigned ORD  = 3;
  localparam int unsigned LAT  = ORD + 1;
  localparam int unsigned LAT2 = 3;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] din, dout;
  logic       dval, serr;
  logic       rst2, en2;
  logic [1:0] din2, dout2;
  logic       dval2, serr2;
`ifdef HDBN_B_STATS_EN
  logic [15:0] bc, vc, bc2, vc2;
`endif

  always #5 clk = ~clk;

  hdbn_b_insert #(.ORDER(ORD), .FIRST_B(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .origin_data(din),
    .encoding_data(dout), .encoding_data_instruction(dval), .sym_err(serr)
`ifdef HDBN_B_STATS_EN
    , .b_count(bc), .v_count(vc)
`endif
  );

  hdbn_b_insert #(.ORDER(2), .FIRST_B(1'b1)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .origin_data(din2),
    .encoding_data(dout2), .encoding_data_instruction(dval2), .sym_err(serr2)
`ifdef HDBN_B_STATS_EN
    , .b_count(bc2), .v_count(vc2)
`endif
  );

  typedef struct {
    logic       en;
    logic [1:0] din;
    logic [1:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]  sym;
    int unsigned due;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(negedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic observe();
    exp_t e;
    logic exp_v;
    while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    chk("out_valid", dval, exp_v);
    if (exp_v) begin
      e = sb.pop_front();
      chk("out_sym", dout, e.sym);
    end else begin
      chk("idle_data", dout, 2'b00);
    end
  endtask

  // Called at a rising edge; the DUT samples on the following falling edge.
  task automatic step(input logic e, input logic [1:0] d, input logic [1:0] x);
    en  = e;
    din = d;
    if (e) sb.push_back('{x, cyc + LAT});
    @(negedge clk);
    @(posedge clk);
    chk("sym_err", serr, e && (d == 2'b11));
    observe();
  endtask

  task automatic add(input logic e, input logic [1:0] d, input logic [1:0] x);
    vecs.push_back('{e, d, x});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned exp_b, exp_v;
    logic [1:0]  got[4];
    logic [1:0]  ins2[3];
    int          n2, first2;

    rst = 1'b1; rst2 = 1'b1; en = 1'b0; din = 2'b00; en2 = 1'b0; din2 = 2'b00;
    #1 rst = 1'b0; rst2 = 1'b0;
    @(posedge clk);
    chk("rst_data", dout, 2'b00);
    chk("rst_valid", dval, 1'b0);
    chk("rst_err", serr, 1'b0);
    repeat (2) @(posedge clk);
    rst = 1'b1;

    // first V of a burst: no B
    add(1, 2'b01, 2'b01); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    // zero marks since last V: B
    add(1, 2'b00, 2'b11); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    // one mark: odd, no B
    add(1, 2'b01, 2'b01); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    // two-clock gap, state preserved: B
    add(0, 2'b00, 2'b00); add(0, 2'b01, 2'b00);
    add(1, 2'b00, 2'b11); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    // two marks: even, B
    add(1, 2'b01, 2'b01); add(1, 2'b01, 2'b01); add(1, 2'b00, 2'b11); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    // illegal symbol stored as zero, not counted as a mark
    add(1, 2'b01, 2'b01); add(1, 2'b11, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    // full drain to IDLE clears V-seen: first V no B, second V gets B
    for (int i = 0; i < 6; i++) add(0, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    add(1, 2'b00, 2'b11); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    // even parity but a mark in the substitution slot: unchanged
    add(1, 2'b01, 2'b01); add(1, 2'b01, 2'b01); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    // bubble in the substitution slot: unchanged
    add(0, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b10, 2'b10);
    for (int i = 0; i < 6; i++) add(0, 2'b00, 2'b00);

    @(posedge clk);
    exp_b = 0; exp_v = 0;
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].din, vecs[i].exp);
      if (vecs[i].en && vecs[i].exp == 2'b11) exp_b++;
      if (vecs[i].en && vecs[i].din == 2'b10) exp_v++;
    end
    chk("sb_drained", sb.size(), 0);
`ifdef HDBN_B_STATS_EN
    chk("b_count", bc, exp_b);
    chk("v_count", vc, exp_v);
`endif

    // reset mid-burst while sym_err is high
    step(1, 2'b01, 2'b01);
    step(1, 2'b11, 2'b00);
    rst = 1'b0;
    #1;
    chk("rst_mid_data", dout, 2'b00);
    chk("rst_mid_valid", dval, 1'b0);
    chk("rst_mid_err", serr, 1'b0);
    sb.delete();
    en = 1'b0; din = 2'b00;
    repeat (2) @(posedge clk);
    rst = 1'b1;
    // V-seen cleared by reset: no B on this first V
    step(1, 2'b00, 2'b00); step(1, 2'b00, 2'b00); step(1, 2'b00, 2'b00); step(1, 2'b10, 2'b10);
    for (int i = 0; i < 6; i++) step(0, 2'b00, 2'b00);
    chk("sb_drained_rst", sb.size(), 0);

    // ORDER=2, FIRST_B=1: first V obeys parity
    rst2 = 1'b1;
    ins2[0] = 2'b00; ins2[1] = 2'b00; ins2[2] = 2'b10;
    n2 = 0; first2 = -1;
    for (int i = 0; i < 12; i++) begin
      en2  = (i < 3);
      din2 = (i < 3) ? ins2[i] : 2'b00;
      @(negedge clk);
      @(posedge clk);
      if (dval2) begin
        if (first2 < 0) first2 = i;
        if (n2 < 4) got[n2] = dout2;
        n2++;
      end
    end
    chk("o2_count", n2, 3);
    chk("o2_latency", first2, LAT2 - 1);
    chk("o2_sym0", got[0], 2'b11);
    chk("o2_sym1", got[1], 2'b00);
    chk("o2_sym2", got[2], 2'b10);
    chk("o2_err", serr2, 1'b0);
`ifdef HDBN_B_STATS_EN
    chk("o2_b_count", bc2, 1);
    chk("o2_v_count", vc2, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hdbn_b_insert.md
HDBN_B_INSERT -- requirements
Module: hdbn_b_insert

Interface
REQ-001 Parameter ORDER, default 3, SHALL set the code order n; zero-run length = ORDER+1; legal range 2..7.
REQ-002 Parameter FIRST_B, default 0, SHALL select whether the first V of a burst obeys the parity rule (1) or never receives a B (0).
REQ-003 clk  input  1  sole clock; all state SHALL update on its falling edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  input symbol valid, one symbol per clock while high.
REQ-006 origin_data  input  2  symbol code: 00 zero, 01 mark, 10 V marker, 11 illegal.
REQ-007 encoding_data  output  2  symbol code: 00 zero, 01 mark, 10 V, 11 B; forced 00 when encoding_data_instruction is low.
REQ-008 encoding_data_instruction  output  1  output symbol valid.
REQ-009 sym_err  output  1  one-cycle pulse when an accepted input is 11.

Function
REQ-010 Block SHALL hold a delay line of ORDER+1 symbol stages, each with a valid bit; output = oldest stage; latency exactly ORDER+1 clocks.
REQ-011 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on en=1; RUN->DRAIN on en=0; DRAIN->RUN on en=1 with no bubble; DRAIN->IDLE after ORDER+1 clocks without en.
REQ-012 In RUN, each clock SHALL shift origin_data into stage 0 with valid=1; in DRAIN it SHALL shift 00 with valid=0.
REQ-013 An accepted 11 input SHALL be stored as 00 and raise sym_err in the same clock.
REQ-014 Parity bit SHALL toggle on each mark shifted into stage 0 and on each B inserted; it SHALL clear to 0 when a V is shifted in.
REQ-015 When a V is shifted in and (a V has already occurred in this burst, or FIRST_B=1), the symbol moving into the output stage SHALL become 11 (B) if parity is even, else remain 00.
REQ-016 When FIRST_B=0, the first V of a burst SHALL never cause a B.
REQ-017 B substitution SHALL only replace a 00 symbol with valid=1; a non-zero or invalid symbol SHALL pass unchanged.
REQ-018 A V and a substitution decision arriving in the same clock as the en falling edge SHALL not occur, because en low means no symbol is accepted.
REQ-019 DRAIN->RUN SHALL preserve parity and the "V seen" flag; entering IDLE SHALL clear both.
REQ-020 Input in IDLE with en=0 SHALL be ignored entirely.

Reset
REQ-021 rst low SHALL immediately clear all stages and valid bits and the parity and "V seen" flags, set state IDLE, and drive encoding_data=00, encoding_data_instruction=0, sym_err=0.
REQ-022 Reset asserted mid-burst SHALL discard all in-flight symbols with no partial output after release.
REQ-023 After release, the first accepted symbol SHALL appear at the output ORDER+1 clocks later.

Configuration
REQ-024 With HDBN_B_STATS_EN defined, outputs b_count[15:0] and v_count[15:0] SHALL count B insertions and V symbols output, saturating at FFFF, cleared by rst only.
REQ-025 Without HDBN_B_STATS_EN, those ports and counters SHALL be absent and all other behaviour identical.

Verification (ORDER=3 unless stated)
REQ-026 Reset, en=1, input 01,00,00,00,10 -> output after 4 clocks: 01,00,00,00,10 (first V, FIRST_B=0, no B).
REQ-027 Continue with 00,00,00,10 (zero marks since last V) -> output 11,00,00,10; b_count +1 if enabled.
REQ-028 After a V, input 01,00,00,00,10 -> output 01,00,00,00,10 (odd parity, no B).
REQ-029 en low for 2 clocks mid-burst, then high -> valid output gap of exactly 2 clocks; parity preserved; stream continues correctly.
REQ-030 Inject 11 -> sym_err high one clock, output 00 at that slot 4 clocks later; assert rst mid-burst -> outputs 00/0 immediately.
REQ-031 ORDER=2, FIRST_B=1, input 00,00,10 after reset -> output 11,00,10.
